// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic / pedestrian signal blocks.
// Light encodings, pedestrian state enum, lamp payload struct, and a
// legality check for the one-hot vehicle light vector.
package traffic_pkg;

   localparam int unsigned LIGHT_W = 3;

   localparam logic [LIGHT_W-1:0] LIGHT_RED = 3'b100;
   localparam logic [LIGHT_W-1:0] LIGHT_YEL = 3'b010;
   localparam logic [LIGHT_W-1:0] LIGHT_GRN = 3'b001;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      WALK  = 2'd1,
      FLASH = 2'd2,
      FAULT = 2'd3
   } ped_state_e;

   // Registered lamp drive toward the crossing
   typedef struct packed {
      logic walk;
      logic dont_walk;
      logic fault;
   } ped_lamps_t;

   // True only for the three one-hot encodings
   function automatic logic light_legal(input logic [LIGHT_W-1:0] l);
      return (l == LIGHT_RED) || (l == LIGHT_YEL) || (l == LIGHT_GRN);
   endfunction

endpackage

// File: rtl/ped_signal_ctrl_if.sv
// Pedestrian controller bus.
//   light       : vehicle light vector (one-hot red/yellow/green)
//   ped_btn     : debounced push-button level
//   walk        : WALK lamp
//   dont_walk   : DON'T-WALK lamp
//   req_pending : crossing request waiting for the next red onset
//   fault       : sticky illegal-encoding flag
// master drives light/ped_btn; slave (the controller) drives the lamps.
interface ped_signal_ctrl_if;
   import traffic_pkg::*;

   logic [LIGHT_W-1:0] light;
   logic               ped_btn;
   logic               walk;
   logic               dont_walk;
   logic               req_pending;
   logic               fault;

   modport master (
      output light, ped_btn,
      input  walk, dont_walk, req_pending, fault
   );

   modport slave (
      input  light, ped_btn,
      output walk, dont_walk, req_pending, fault
   );

endinterface

// File: rtl/phase_counter.sv
// Loadable down-counter with a zero flag.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (wins over dec)
//   load_val  : value to load
//   dec       : decrement; holds at zero, never wraps
//   zero_c    : count == 0, decoded from the count register
module phase_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_c
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst)                          count_q <= '0;
      else if (load)                    count_q <= load_val;
      else if (dec && (count_q != '0))  count_q <= count_q - CNT_W'(1);
   end

   assign zero_c = (count_q == '0);

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller downstream of the vehicle light FSM.
// Grants WALK only at a red onset, follows with flashing DON'T-WALK,
// drops to STOP the moment red is withdrawn, and latches FAULT on any
// illegal light encoding until reset.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ped_signal_ctrl_if (light/ped_btn in, lamps out)
module ped_signal_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned WALK_CYCLES  = 6,
   parameter int unsigned FLASH_CYCLES = 4,
   parameter int unsigned FLASH_HALF   = 1,
   parameter int unsigned CNT_W        = 8
) (
   input  logic               clk,
   input  logic               rst,
   ped_signal_ctrl_if.slave   bus
);

   localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(FLASH_HALF - 1);

   ped_state_e         state_q, state_d;
   logic [LIGHT_W-1:0] light_q;
   logic               req_q, req_d;
   logic               phase_q, phase_d;
   ped_lamps_t         lamps_q, lamps_d;

   logic               cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0]   cnt_val;
   logic               div_load, div_dec, div_zero;

   logic               red_c, red_onset_c;

   assign red_c       = (bus.light == LIGHT_RED);
   assign red_onset_c = red_c && (light_q != LIGHT_RED);

   // Phase length counter (WALK / FLASH duration)
   phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero_c   (cnt_zero)
   );

   // Flash half-period divider
   phase_counter #(.CNT_W(CNT_W)) u_flash_div (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .load_val (HALF_LOAD),
      .dec      (div_dec),
      .zero_c   (div_zero)
   );

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= STOP;
         light_q <= LIGHT_GRN;
         req_q   <= 1'b0;
         phase_q <= 1'b1;
         lamps_q <= '{walk: 1'b0, dont_walk: 1'b1, fault: 1'b0};
      end else begin
         state_q <= state_d;
         light_q <= bus.light;
         req_q   <= req_d;
         phase_q <= phase_d;
         lamps_q <= lamps_d;
      end
   end

   // Next state, counter control and next lamp values
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      phase_d  = phase_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_dec  = 1'b0;
      div_load = 1'b0;
      div_dec  = 1'b0;

      if (!light_legal(bus.light)) begin
         state_d = FAULT;
         req_d   = 1'b0;
      end else begin
         unique case (state_q)
            STOP: begin
               if (red_onset_c && (req_q || bus.ped_btn)) begin
                  state_d  = WALK;
                  req_d    = 1'b0;
                  cnt_load = 1'b1;
                  cnt_val  = WALK_LOAD;
               end else if (bus.ped_btn) begin
                  req_d = 1'b1;
               end
            end
            WALK: begin
               if (!red_c) begin
                  state_d  = STOP;
                  req_d    = 1'b0;
                  cnt_load = 1'b1;
               end else if (cnt_zero) begin
                  state_d  = FLASH;
                  cnt_load = 1'b1;
                  cnt_val  = FLASH_LOAD;
                  phase_d  = 1'b1;
                  div_load = 1'b1;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
            FLASH: begin
               if (!red_c || cnt_zero) begin
                  state_d  = STOP;
                  req_d    = 1'b0;
                  cnt_load = 1'b1;
               end else begin
                  cnt_dec = 1'b1;
                  if (div_zero) begin
                     phase_d  = ~phase_q;
                     div_load = 1'b1;
                  end else begin
                     div_dec = 1'b1;
                  end
               end
            end
            FAULT: begin
               req_d = 1'b0;
            end
            default: begin
               state_d = FAULT;
               req_d   = 1'b0;
            end
         endcase
      end

      // Lamps follow the state being entered so they change on the transition edge
      lamps_d = '{walk: 1'b0, dont_walk: 1'b1, fault: 1'b0};
      unique case (state_d)
         WALK:    lamps_d = '{walk: 1'b1, dont_walk: 1'b0,    fault: 1'b0};
         FLASH:   lamps_d = '{walk: 1'b0, dont_walk: phase_d, fault: 1'b0};
         FAULT:   lamps_d = '{walk: 1'b0, dont_walk: 1'b1,    fault: 1'b1};
         default: lamps_d = '{walk: 1'b0, dont_walk: 1'b1,    fault: 1'b0};
      endcase
   end

   assign bus.walk        = lamps_q.walk;
   assign bus.dont_walk   = lamps_q.dont_walk;
   assign bus.fault       = lamps_q.fault;
   assign bus.req_pending = req_q;

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Bench for ped_signal_ctrl: a vector table plus hand-written corner
// sequences. Each step drives inputs on the falling edge, queues the
// expected {walk, dont_walk, req_pending, fault} for the next rising
// edge, and checks it 1 time unit after that edge.
module tb_ped_signal_ctrl;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   // Expected {walk, dont_walk, req_pending, fault}
   localparam logic [3:0] E_STOP  = 4'b0100;
   localparam logic [3:0] E_REQ   = 4'b0110;
   localparam logic [3:0] E_WALK  = 4'b1000;
   localparam logic [3:0] E_FL_ON = 4'b0100;
   localparam logic [3:0] E_FL_OF = 4'b0000;
   localparam logic [3:0] E_FAULT = 4'b0101;

   typedef struct {
      logic       rst;
      logic [2:0] light;
      logic       btn;
      logic [3:0] exp;
      string      name;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ped_signal_ctrl_if bus ();

   ped_signal_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   vec_t       vecs[$];
   logic [3:0] sb_q[$];
   string      sb_name[$];
   int         n_cmp  = 0;
   int         n_fail = 0;

   function automatic void add(input logic r, input logic [2:0] l, input logic b,
                               input logic [3:0] e, input string nm);
      vec_t v;
      v.rst = r; v.light = l; v.btn = b; v.exp = e; v.name = nm;
      vecs.push_back(v);
   endfunction

   // Drive one cycle of stimulus, queue its expectation, then check it
   task automatic step(input logic r, input logic [2:0] l, input logic b,
                       input logic [3:0] e, input string nm);
      logic [3:0] got;
      logic [3:0] want;
      string      wname;
      @(negedge clk);
      rst         = r;
      bus.light   = l;
      bus.ped_btn = b;
      sb_q.push_back(e);
      sb_name.push_back(nm);
      @(posedge clk);
      #1;
      got = {bus.walk, bus.dont_walk, bus.req_pending, bus.fault};
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, got w/dw/req/flt=%b", nm, got);
      end else begin
         want  = sb_q.pop_front();
         wname = sb_name.pop_front();
         if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got w/dw/req/flt=%b expected %b", wname, got, want);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.light   = GRN;
      bus.ped_btn = 1'b0;

      // Full request cycle: press, red onset, 6 WALK, 4 flashing, STOP
      add(1, GRN, 0, E_STOP,  "reset");
      add(0, GRN, 1, E_REQ,   "press_latch");
      add(0, GRN, 0, E_REQ,   "req_hold");
      add(0, RED, 0, E_WALK,  "onset_walk1");
      add(0, RED, 0, E_WALK,  "walk2");
      add(0, RED, 0, E_WALK,  "walk3");
      add(0, RED, 0, E_WALK,  "walk4");
      add(0, RED, 0, E_WALK,  "walk5");
      add(0, RED, 0, E_WALK,  "walk6");
      add(0, RED, 0, E_FL_ON, "flash1_on");
      add(0, RED, 0, E_FL_OF, "flash2_off");
      add(0, RED, 0, E_FL_ON, "flash3_on");
      add(0, RED, 0, E_FL_OF, "flash4_off");
      add(0, RED, 0, E_STOP,  "stop_after_flash");
      add(0, RED, 0, E_STOP,  "red_held_no_retrigger");
      // Vehicle cycle without a press
      add(0, GRN, 0, E_STOP,  "nopress_grn");
      add(0, YEL, 0, E_STOP,  "nopress_yel");
      add(0, RED, 0, E_STOP,  "nopress_red_onset");
      add(0, RED, 0, E_STOP,  "nopress_red_held");
      // Press mid-red waits for the next onset
      add(0, RED, 1, E_REQ,   "press_mid_red");
      add(0, RED, 0, E_REQ,   "mid_red_wait");
      add(0, GRN, 0, E_REQ,   "wait_grn");
      add(0, YEL, 0, E_REQ,   "wait_yel");
      add(0, RED, 0, E_WALK,  "next_onset_walk");

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].rst, vecs[i].light, vecs[i].btn, vecs[i].exp, vecs[i].name);

      // Red withdrawn in WALK with counter at 3
      step(0, RED, 0, E_WALK, "walk_cnt4");
      step(0, RED, 0, E_WALK, "walk_cnt3");
      step(0, GRN, 0, E_STOP, "safety_red_to_grn");

      // Button in the onset cycle itself, press during WALK ignored, yellow abort
      step(0, GRN, 0, E_STOP, "pre_onset_grn");
      step(0, RED, 1, E_WALK, "btn_at_onset");
      step(0, RED, 1, E_WALK, "press_in_walk_ignored");
      step(0, YEL, 0, E_STOP, "safety_red_to_yel");

      // Illegal encoding latches FAULT until reset
      step(0, GRN,    0, E_STOP,  "pre_fault");
      step(0, 3'b110, 0, E_FAULT, "fault_set");
      step(0, GRN,    1, E_FAULT, "fault_hold_press");
      step(0, RED,    0, E_FAULT, "fault_hold_red");
      step(0, RED,    1, E_FAULT, "fault_hold_red_press");
      step(0, 3'b000, 0, E_FAULT, "fault_hold_zero");
      step(1, GRN,    0, E_STOP,  "fault_cleared_by_rst");
      step(0, GRN,    0, E_STOP,  "after_fault_reset");

      // Reset in FLASH drops to STOP and loses the request
      step(0, GRN, 1, E_REQ,   "rf_press");
      step(0, RED, 0, E_WALK,  "rf_walk1");
      for (int i = 2; i <= 6; i++)
         step(0, RED, 0, E_WALK, $sformatf("rf_walk%0d", i));
      step(0, RED, 0, E_FL_ON, "rf_flash_on");
      step(0, RED, 0, E_FL_OF, "rf_flash_off");
      step(1, RED, 0, E_STOP,  "rst_in_flash");
      step(0, RED, 0, E_STOP,  "post_rst_red_no_req");

      // Reset drops a pending request
      step(0, GRN, 1, E_REQ,  "req_before_rst");
      step(1, GRN, 0, E_STOP, "rst_drops_req");
      step(0, RED, 0, E_STOP, "onset_after_dropped_req");

      if (sb_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
